wb_initiator: RTL and testbench

- Single-channel Wishbone initiator: drives one port (A or B) of the dual-port Wishbone RAM block.
- Accepts one command per handshake from a local client, issues the Wishbone request, and holds strobe through stall.
- Waits for ack or err, then returns one response pulse.
- Enforces a transaction timeout and counts stall cycles for contention characterisation; two instances contend on the shared RAMs.

---
 rtl/wb_initiator.sv | 173 +++++++++++++++++
 tb/tb_wb_initiator.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone initiator: one client command -> one Wishbone request -> one
// response pulse. Holds the strobe through stall, bounds each transaction with a timeout and
// keeps a saturating count of stalled strobe cycles.
module wb_initiator #(
  parameter int unsigned A_WIDTH     = 8,
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [A_WIDTH:0]       cmd_addr,
  input  logic [3:0]             cmd_sel,
  input  logic [31:0]            cmd_wdata,
  output logic                   rsp_valid,
  output logic [31:0]            rsp_data,
  output logic                   rsp_err,
  output logic                   rsp_timeout,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic                   wb_stb_o,
  output logic [A_WIDTH:0]       wb_addr_o,
  output logic [3:0]             wb_we_o,
  output logic [31:0]            wb_data_o,
  input  logic                   wb_ack_i,
  input  logic                   wb_stall_i,
  input  logic                   wb_err_i,
  input  logic [31:0]            wb_data_i
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  localparam int unsigned    TmoW    = $clog2(TIMEOUT);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [A_WIDTH:0]       addr_q, addr_d;
  logic [3:0]             we_q, we_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [TmoW-1:0]        tmo_q, tmo_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   rsp_tmo_q, rsp_tmo_d;
  logic [31:0]            rsp_data_q, rsp_data_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic fin_ok, fin_err, fin_tmo, stall_hit, tmo_hit;

  // State register; async reset drops the strobe immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and completion decode. Responder ack/err beats the timeout on the same edge.
  always_comb begin
    state_d   = state_q;
    fin_ok    = 1'b0;
    fin_err   = 1'b0;
    fin_tmo   = 1'b0;
    stall_hit = 1'b0;
    tmo_hit   = (tmo_q == TmoLast);
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) state_d = StReq;
      end
      StReq: begin
        if (wb_err_i) begin
          fin_err = 1'b1;
        end else if (!wb_stall_i && wb_ack_i) begin
          fin_ok = 1'b1;
        end else if (tmo_hit) begin
          fin_tmo = 1'b1;
        end else if (!wb_stall_i) begin
          state_d = StWait;
        end
        // An ack presented while stalled is not a completion; the cycle still counts as stalled.
        stall_hit = wb_stall_i && !wb_err_i;
      end
      StWait: begin
        if (wb_err_i) begin
          fin_err = 1'b1;
        end else if (wb_ack_i) begin
          fin_ok = 1'b1;
        end else if (tmo_hit) begin
          fin_tmo = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (fin_ok || fin_err || fin_tmo) state_d = StIdle;
  end

  // State-decoded outputs; cmd_ready is forced low while reset is asserted.
  always_comb begin
    cmd_ready = (state_q == StIdle) && rst_n;
    wb_stb_o  = (state_q == StReq);
  end

  // Request capture, timeout count, stall count and response fields.
  always_comb begin
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    tmo_d       = tmo_q;
    stall_d     = stall_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_tmo_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    if (state_q == StIdle) begin
      if (cmd_valid) begin
        addr_d  = cmd_addr;
        we_d    = cmd_write ? cmd_sel : 4'b0000;
        wdata_d = cmd_wdata;
        tmo_d   = '0;
      end
    end else begin
      tmo_d = tmo_q + TmoW'(1);
    end
    if (stall_hit && (stall_q != '1)) stall_d = stall_q + STALL_CNT_W'(1);
    if (fin_ok) begin
      rsp_valid_d = 1'b1;
      // A write (any byte enable set) returns zero data.
      rsp_data_d  = (we_q == 4'b0000) ? wb_data_i : 32'h0;
    end
    if (fin_err || fin_tmo) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_tmo_d   = fin_tmo;
      rsp_data_d  = 32'h0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      we_q        <= 4'b0000;
      wdata_q     <= 32'h0;
      tmo_q       <= '0;
      stall_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
      rsp_data_q  <= 32'h0;
    end else begin
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      tmo_q       <= tmo_d;
      stall_q     <= stall_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tmo_q   <= rsp_tmo_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign wb_addr_o   = addr_q;
  assign wb_we_o     = we_q;
  assign wb_data_o   = wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_tmo_q;
  assign rsp_data    = rsp_data_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Bench for wb_initiator: two instances share a behavioural RAM responder. A driver pushes the
// expected response (from a word-level memory model and the latency rule) into a per-port
// queue; a negedge monitor pops and compares whenever rsp_valid is seen.
module tb_wb_initiator;
  localparam int AW  = 8;
  localparam int TMO = 16;
  localparam int SCW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic        cmd_write [2];
  logic [AW:0] cmd_addr  [2];
  logic [3:0]  cmd_sel   [2];
  logic [31:0] cmd_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_data  [2];
  logic        rsp_err   [2];
  logic        rsp_tmo   [2];
  logic [SCW-1:0] stall_count [2];
  logic        wb_stb    [2];
  logic [AW:0] wb_addr   [2];
  logic [3:0]  wb_we     [2];
  logic [31:0] wb_wdata  [2];
  logic        wb_ack    [2];
  logic        wb_stall  [2];
  logic        wb_err    [2];
  logic [31:0] wb_rdata  [2];

  wb_initiator #(.A_WIDTH(AW), .TIMEOUT(TMO), .STALL_CNT_W(SCW)) u_port_a (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write[0]),
    .cmd_addr(cmd_addr[0]), .cmd_sel(cmd_sel[0]), .cmd_wdata(cmd_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
    .rsp_timeout(rsp_tmo[0]), .stall_count(stall_count[0]),
    .wb_stb_o(wb_stb[0]), .wb_addr_o(wb_addr[0]), .wb_we_o(wb_we[0]), .wb_data_o(wb_wdata[0]),
    .wb_ack_i(wb_ack[0]), .wb_stall_i(wb_stall[0]), .wb_err_i(wb_err[0]),
    .wb_data_i(wb_rdata[0])
  );

  wb_initiator #(.A_WIDTH(AW), .TIMEOUT(TMO), .STALL_CNT_W(SCW)) u_port_b (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write[1]),
    .cmd_addr(cmd_addr[1]), .cmd_sel(cmd_sel[1]), .cmd_wdata(cmd_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
    .rsp_timeout(rsp_tmo[1]), .stall_count(stall_count[1]),
    .wb_stb_o(wb_stb[1]), .wb_addr_o(wb_addr[1]), .wb_we_o(wb_we[1]), .wb_data_o(wb_wdata[1]),
    .wb_ack_i(wb_ack[1]), .wb_stall_i(wb_stall[1]), .wb_err_i(wb_err[1]),
    .wb_data_i(wb_rdata[1])
  );

  // s = stall cycles before the responder lets the strobe through, d = extra cycles to ack/err.
  typedef struct {
    logic [AW:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    int          s;
    int          d;
    bit          err_mode;
  } req_t;

  typedef struct {
    logic [31:0] data;
    bit          err;
    bit          tmo;
    int          lat;
    int          stalls;
  } rsp_t;

  req_t        req_q [2][$];
  rsp_t        exp_q [2][$];
  int          acc_q [2][$];
  int          stall_exp [2];
  bit          busy [2];
  logic [31:0] mdl_mem [512];
  logic [31:0] ram [512];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // Behavioural RAM port: stalls, then acks (or errs) after the configured delay.
  task automatic responder(input int p);
    req_t r;
    forever begin
      @(negedge clk);
      if (!(rst_n && wb_stb[p])) continue;
      if (req_q[p].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL p%0d unexpected_stb: got stb=1, required no request", p);
        continue;
      end
      r = req_q[p].pop_front();
      busy[p] = 1'b1;
      chk($sformatf("p%0d req_addr", p), 32'(wb_addr[p]), 32'(r.addr));
      chk($sformatf("p%0d req_we", p), 32'(wb_we[p]), 32'(r.we));
      if (r.we != 4'h0) chk($sformatf("p%0d req_wdata", p), wb_wdata[p], r.wdata);
      for (int i = 0; i < r.s; i++) begin
        wb_stall[p] = 1'b1;
        @(negedge clk);
      end
      wb_stall[p] = 1'b0;
      for (int i = 0; i < r.d; i++) @(negedge clk);
      if (r.err_mode) begin
        wb_err[p] = 1'b1;
      end else begin
        wb_ack[p] = 1'b1;
        if (r.we == 4'h0) wb_rdata[p] = ram[r.addr];
        else ram[r.addr] = merge(ram[r.addr], r.wdata, r.we);
      end
      @(negedge clk);
      wb_ack[p]   = 1'b0;
      wb_err[p]   = 1'b0;
      wb_rdata[p] = $urandom;
      busy[p]     = 1'b0;
    end
  endtask

  // Issue one command; the expectation follows from the memory model and latency s+1+d,
  // capped by the timeout (ack on the timeout edge itself still wins).
  task automatic issue(input int p, input bit wr, input logic [AW:0] addr,
                       input logic [3:0] sel, input logic [31:0] wd,
                       input int s, input int d, input bit em);
    req_t r;
    rsp_t e;
    int   k;
    int   t;
    r.addr = addr;
    r.we = wr ? sel : 4'h0;
    r.wdata = wd;
    r.s = s;
    r.d = d;
    r.err_mode = em;
    k = s + 1 + d;
    stall_exp[p] += s;
    e.stalls = stall_exp[p];
    e.data = 32'h0;
    e.err = 1'b0;
    e.tmo = 1'b0;
    if (k > TMO) begin
      e.lat = TMO;
      e.err = 1'b1;
      e.tmo = 1'b1;
    end else begin
      e.lat = k;
      if (em) e.err = 1'b1;
      else if (r.we == 4'h0) e.data = mdl_mem[addr];
      else mdl_mem[addr] = merge(mdl_mem[addr], wd, r.we);
    end
    req_q[p].push_back(r);
    exp_q[p].push_back(e);
    @(negedge clk);
    cmd_valid[p] = 1'b1;
    cmd_write[p] = wr;
    cmd_addr[p]  = addr;
    cmd_sel[p]   = sel;
    cmd_wdata[p] = wd;
    t = 0;
    while (!cmd_ready[p] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready[p]) begin
      checks++;
      errors++;
      $display("FAIL p%0d accept_wait: got cmd_ready=0 for 200 cycles, required 1", p);
      cmd_valid[p] = 1'b0;
      return;
    end
    acc_q[p].push_back(cyc + 1);
    @(posedge clk);
    #1;
    cmd_valid[p] = 1'b0;
    cmd_write[p] = $urandom_range(0, 1);
    cmd_addr[p]  = (AW+1)'($urandom);
    cmd_sel[p]   = 4'($urandom);
    cmd_wdata[p] = $urandom;
  endtask

  task automatic wait_idle(input int p);
    int t;
    t = 0;
    while ((busy[p] || exp_q[p].size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("p%0d idle_wait_expired", p), 32'(t >= 100), 32'h0);
    repeat (2) @(negedge clk);
  endtask

  task automatic rand_port(input int p);
    for (int i = 0; i < 40; i++) begin
      bit          wr;
      bit          em;
      int          mode;
      int          s;
      int          d;
      logic [AW:0] a;
      a    = {p[0], 8'($urandom_range(0, 15))};
      mode = $urandom_range(0, 9);
      s    = $urandom_range(0, 4);
      d    = $urandom_range(0, 3);
      wr   = 1'($urandom_range(0, 1));
      em   = 1'b0;
      if (mode == 0) begin
        // Reads only: a late ack after timeout must not change the RAM.
        wr = 1'b0;
        d  = $urandom_range(13, 20);
      end else if (mode <= 2) begin
        em = 1'b1;
      end
      issue(p, wr, a, 4'($urandom), $urandom, s, d, em);
      if (mode == 0) wait_idle(p);
    end
    wait_idle(p);
  endtask

  // Scoreboard monitor plus strobe-stability and response-hold checks.
  logic        prev_stb  [2];
  logic [AW:0] prev_addr [2];
  logic [3:0]  prev_we   [2];
  logic [31:0] prev_wd   [2];
  logic        prev_rv   [2];
  logic [31:0] prev_rd   [2];

  always @(negedge clk) begin : mon
    rsp_t e;
    int   a;
    for (int p = 0; p < 2; p++) begin
      if (rst_n) begin
        if (rsp_valid[p]) begin
          if (exp_q[p].size() == 0 || acc_q[p].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL p%0d unexpected_rsp: got rsp_valid=1, required no response", p);
          end else begin
            e = exp_q[p].pop_front();
            a = acc_q[p].pop_front();
            chk($sformatf("p%0d rsp_data", p), rsp_data[p], e.data);
            chk($sformatf("p%0d rsp_err", p), 32'(rsp_err[p]), 32'(e.err));
            chk($sformatf("p%0d rsp_timeout", p), 32'(rsp_tmo[p]), 32'(e.tmo));
            chk($sformatf("p%0d latency", p), 32'(cyc - a), 32'(e.lat));
            chk($sformatf("p%0d stall_count", p), 32'(stall_count[p]), 32'(e.stalls));
          end
        end else if (prev_rv[p]) begin
          chk($sformatf("p%0d rsp_data_hold", p), rsp_data[p], prev_rd[p]);
          chk($sformatf("p%0d rsp_err_clear", p), 32'(rsp_err[p]), 32'h0);
          chk($sformatf("p%0d rsp_timeout_clear", p), 32'(rsp_tmo[p]), 32'h0);
        end
        if (wb_stb[p] && prev_stb[p]) begin
          chk($sformatf("p%0d stb_addr_stable", p), 32'(wb_addr[p]), 32'(prev_addr[p]));
          chk($sformatf("p%0d stb_we_stable", p), 32'(wb_we[p]), 32'(prev_we[p]));
          chk($sformatf("p%0d stb_wdata_stable", p), wb_wdata[p], prev_wd[p]);
        end
      end
      prev_stb[p]  <= wb_stb[p];
      prev_addr[p] <= wb_addr[p];
      prev_we[p]   <= wb_we[p];
      prev_wd[p]   <= wb_wdata[p];
      prev_rv[p]   <= rsp_valid[p];
      prev_rd[p]   <= rsp_data[p];
    end
  end

  task automatic check_reset_values(input string tag);
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("p%0d %s cmd_ready", p, tag), 32'(cmd_ready[p]), 32'h0);
      chk($sformatf("p%0d %s stb", p, tag), 32'(wb_stb[p]), 32'h0);
      chk($sformatf("p%0d %s addr", p, tag), 32'(wb_addr[p]), 32'h0);
      chk($sformatf("p%0d %s we", p, tag), 32'(wb_we[p]), 32'h0);
      chk($sformatf("p%0d %s wdata", p, tag), wb_wdata[p], 32'h0);
      chk($sformatf("p%0d %s rsp_valid", p, tag), 32'(rsp_valid[p]), 32'h0);
      chk($sformatf("p%0d %s rsp_err", p, tag), 32'(rsp_err[p]), 32'h0);
      chk($sformatf("p%0d %s rsp_data", p, tag), rsp_data[p], 32'h0);
      chk($sformatf("p%0d %s stall_count", p, tag), 32'(stall_count[p]), 32'h0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    for (int p = 0; p < 2; p++) begin
      cmd_valid[p] = 1'b0;
      cmd_write[p] = 1'b0;
      cmd_addr[p]  = '0;
      cmd_sel[p]   = 4'h0;
      cmd_wdata[p] = 32'h0;
      wb_ack[p]    = 1'b0;
      wb_stall[p]  = 1'b0;
      wb_err[p]    = 1'b0;
      wb_rdata[p]  = $urandom;
      stall_exp[p] = 0;
      busy[p]      = 1'b0;
    end
    for (int i = 0; i < 512; i++) begin
      ram[i]     = $urandom;
      mdl_mem[i] = ram[i];
    end
    fork
      responder(0);
      responder(1);
    join_none

    #1 rst_n = 1'b0;
    #1 check_reset_values("por");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("p0 ready_after_release", 32'(cmd_ready[0]), 32'h1);
    chk("p1 ready_after_release", 32'(cmd_ready[1]), 32'h1);

    // Full write, read back, byte-masked write, read back, sel=0 write behaves as read.
    issue(0, 1'b1, 9'h000, 4'hF, 32'hdeaddead, 0, 1, 1'b0);
    issue(0, 1'b0, 9'h000, 4'h3, 32'h0, 0, 1, 1'b0);
    issue(0, 1'b1, 9'h000, 4'hC, 32'hfeedbeef, 1, 0, 1'b0);
    issue(0, 1'b0, 9'h000, 4'h0, 32'h0, 0, 0, 1'b0);
    issue(0, 1'b1, 9'h005, 4'h0, 32'h11111111, 0, 0, 1'b0);
    wait_idle(0);

    // Both ports on the same word; B is stalled three cycles.
    fork
      issue(0, 1'b0, 9'h103, 4'hF, 32'h0, 0, 0, 1'b0);
      issue(1, 1'b0, 9'h103, 4'hF, 32'h0, 3, 0, 1'b0);
    join
    wait_idle(0);
    wait_idle(1);

    // Timeout with a late ack afterwards; ack exactly on the timeout edge; one edge past it.
    issue(0, 1'b0, 9'h030, 4'hF, 32'h0, 0, 25, 1'b0);
    wait_idle(0);
    issue(0, 1'b0, 9'h031, 4'hF, 32'h0, 0, 15, 1'b0);
    wait_idle(0);
    issue(0, 1'b0, 9'h032, 4'hF, 32'h0, 3, 12, 1'b0);
    wait_idle(0);
    issue(0, 1'b0, 9'h033, 4'hF, 32'h0, 0, 16, 1'b0);
    wait_idle(0);

    // Error completions; the errored write must leave memory untouched.
    issue(0, 1'b1, 9'h020, 4'hF, 32'h12345678, 0, 0, 1'b1);
    issue(0, 1'b1, 9'h021, 4'hF, 32'h9abcdef0, 2, 1, 1'b1);
    issue(0, 1'b0, 9'h020, 4'hF, 32'h0, 0, 0, 1'b0);
    wait_idle(0);

    // Reset while port A is stalled in the request phase.
    issue(0, 1'b0, 9'h010, 4'h0, 32'h0, 5, 30, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("p0 stb_before_reset", 32'(wb_stb[0]), 32'h1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("mid_reset");
    exp_q[0].delete();
    acc_q[0].delete();
    stall_exp[0] = 0;
    stall_exp[1] = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("p0 ready_after_mid_reset", 32'(cmd_ready[0]), 32'h1);
    wait_idle(0);
    issue(0, 1'b1, 9'h011, 4'hF, 32'ha5a5a5a5, 0, 0, 1'b0);
    issue(0, 1'b0, 9'h011, 4'hF, 32'h0, 1, 1, 1'b0);
    wait_idle(0);

    // Randomised traffic on both ports, each in its own RAM bank.
    fork
      rand_port(0);
      rand_port(1);
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
